// File: rtl/demux_stream_router_pkg.sv
// Shared types and constants for the demux_stream_router slice.
package demux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Select width never collapses to zero, even for a two-channel build.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_stream_router_slot.sv
// One-entry output slot with load/drain control and an optional delivered-word
// counter built only when DEMUX_STREAM_CNT_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free,
  output logic [CNT_W-1:0]  cnt
);

  slot_state_t state;
  slot_state_t state_next;
  logic        drain;

  assign valid = (state == SLOT_FULL);
  assign drain = valid & ready;
  assign free  = !valid | ready;

  // A reload in the drain cycle keeps the slot full with no bubble.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = SLOT_FULL;
    end else if (drain) begin
      state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        data <= load_data;
      end
    end
  end

`ifdef DEMUX_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drain && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-N stream demultiplexer with unicast/broadcast routing.
// Optional per-channel handshake counters: define DEMUX_STREAM_CNT_EN.
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = clog2_min1(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel,
  output logic [N_OUT*CNT_W-1:0]  cnt
);

  logic [N_OUT-1:0] sel_onehot;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             sel_in_range;
  logic             accept;

  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_onehot[k] = (in_sel == SEL_W'(k));
    end
  end

  assign sel_in_range = |sel_onehot;

  // An out-of-range select is always accepted so the producer never stalls on it.
  always_comb begin
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_in_range) begin
      in_ready = |(sel_onehot & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load = in_bcast ? {N_OUT{1'b1}} : sel_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= accept & !in_bcast & !sel_in_range;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W]),
      .free     (free[k]),
      .cnt      (cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
